// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl: sequencer for the fill/drain LED shift pattern.
// The LED shift register advances only on a programmable step tick. Each
// sweep fills WIDTH LEDs, dwells one step at all-ones, drains WIDTH LEDs and
// spends one turn step at all-zeros, which is where completion is reported.
// The sweep direction is latched at the sweep boundary, and in auto mode it
// flips every REPEAT sweeps.
module led_sweep_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DIV_W  = 24,
    parameter int REPEAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_mode,
    input  logic             mode_in,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic             cur_mode,
    output logic             sweep_done,
    output logic [7:0]       sweep_cnt
);

    localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LED_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LED_LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q,        state_d;
    logic [WIDTH-1:0]   led_q,          led_d;
    logic               busy_q,         busy_d;
    logic               cur_mode_q,     cur_mode_d;
    logic               sweep_done_q,   sweep_done_d;
    logic [7:0]         sweep_cnt_q,    sweep_cnt_d;
    logic [DIV_W-1:0]   cnt_q,          cnt_d;
    logic [REP_W-1:0]   rep_q,          rep_d;
    logic               stop_pending_q, stop_pending_d;
    logic               tick;

    // Next-state logic: prescaler, sweep FSM, direction and sweep bookkeeping.
    always_comb begin
        // NOTE: every *_d gets a default before any branch so no latch is inferred.
        state_d        = state_q;
        led_d          = led_q;
        cur_mode_d     = cur_mode_q;
        sweep_done_d   = 1'b0;
        sweep_cnt_d    = sweep_cnt_q;
        cnt_d          = cnt_q;
        rep_d          = rep_q;
        stop_pending_d = stop_pending_q;

        // ">=" rather than "==" so a shrinking div never forces a long wrap.
        tick = (state_q != IDLE) && (cnt_q >= div);

        if (state_q == IDLE) begin
            cnt_d = '0;
            // A simultaneous stop cancels the start request.
            if (start && !stop) begin
                state_d        = FILL;
                cur_mode_d     = mode_in;
                led_d          = '0;
                sweep_cnt_d    = 8'd0;
                rep_d          = '0;
                stop_pending_d = 1'b0;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
            if (stop) begin
                stop_pending_d = 1'b1;
            end

            if (tick) begin
                if (state_q == FILL) begin
                    if (led_q == ALL_ONES) begin
                        // Dwell step: the pattern holds at all-ones for one tick.
                        state_d = DRAIN;
                    end else if (cur_mode_q) begin
                        led_d = (led_q >> 1) | LED_MSB;
                    end else begin
                        led_d = (led_q << 1) | LED_LSB;
                    end
                end else begin
                    if (led_q == '0) begin
                        // Turn step: the sweep is complete.
                        sweep_done_d = 1'b1;
                        sweep_cnt_d  = sweep_cnt_q + 8'd1;

                        if (auto_mode) begin
                            if (rep_q == REP_LAST) begin
                                cur_mode_d = ~cur_mode_q;
                                rep_d      = '0;
                            end else begin
                                rep_d = rep_q + REP_W'(1);
                            end
                        end else begin
                            cur_mode_d = mode_in;
                            rep_d      = '0;
                        end

                        // A stop raised on this very edge is kept for the next sweep.
                        if (stop_pending_q) begin
                            state_d        = IDLE;
                            stop_pending_d = 1'b0;
                        end else begin
                            state_d = FILL;
                        end
                    end else if (cur_mode_q) begin
                        led_d = led_q >> 1;
                    end else begin
                        led_d = led_q << 1;
                    end
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q        <= IDLE;
            led_q          <= '0;
            busy_q         <= 1'b0;
            cur_mode_q     <= 1'b0;
            sweep_done_q   <= 1'b0;
            sweep_cnt_q    <= 8'd0;
            cnt_q          <= '0;
            rep_q          <= '0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            led_q          <= led_d;
            busy_q         <= busy_d;
            cur_mode_q     <= cur_mode_d;
            sweep_done_q   <= sweep_done_d;
            sweep_cnt_q    <= sweep_cnt_d;
            cnt_q          <= cnt_d;
            rep_q          <= rep_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    assign led        = led_q;
    assign busy       = busy_q;
    assign cur_mode   = cur_mode_q;
    assign sweep_done = sweep_done_q;
    assign sweep_cnt  = sweep_cnt_q;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Scoreboard bench for led_sweep_ctrl. A reference model tracks the sweep as
// a tick index within the 2*WIDTH+2 step sweep and derives the LED pattern
// arithmetically from that index. Expected per-cycle outputs and expected
// sweep-completion events are queued; a monitor pops and compares them.
module tb_led_sweep_ctrl;

    localparam int WIDTH  = 8;
    localparam int DIV_W  = 24;
    localparam int REPEAT = 2;
    localparam int SWEEP  = 2 * WIDTH + 2;

    typedef struct {
        logic [WIDTH-1:0] led;
        logic             busy;
        logic             mode;
        logic             done;
        logic [7:0]       cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, start, stop, auto_mode, mode_in;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] led;
    logic             busy, cur_mode, sweep_done;
    logic [7:0]       sweep_cnt;

    exp_t       exp_q[$];
    logic [8:0] done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit m_busy, m_mode, m_pend, m_done;
    int m_k, m_cnt, m_sweeps, m_rep;

    led_sweep_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W), .REPEAT(REPEAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .auto_mode  (auto_mode),
        .mode_in    (mode_in),
        .div        (div),
        .led        (led),
        .busy       (busy),
        .cur_mode   (cur_mode),
        .sweep_done (sweep_done),
        .sweep_cnt  (sweep_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // LED pattern after k ticks of a sweep in direction m.
    function automatic logic [WIDTH-1:0] led_of(input int k, input bit m);
        logic [WIDTH-1:0] all_ones;
        int j;
        all_ones = '1;
        if (k == 0) return '0;
        if (k <= WIDTH) return m ? (all_ones << (WIDTH - k)) : WIDTH'((1 << k) - 1);
        if (k == WIDTH + 1) return all_ones;
        j = k - WIDTH - 1;
        return m ? (all_ones >> j) : (all_ones << j);
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        bit old_pend;
        m_done = 0;
        if (rst) begin
            m_busy = 0; m_mode = 0; m_pend = 0;
            m_k = 0; m_cnt = 0; m_sweeps = 0; m_rep = 0;
        end else if (!m_busy) begin
            m_cnt = 0;
            if (start && !stop) begin
                m_busy = 1; m_mode = mode_in; m_k = 0;
                m_sweeps = 0; m_rep = 0; m_pend = 0;
            end
        end else begin
            old_pend = m_pend;
            if (stop) m_pend = 1;
            if (m_cnt >= int'(div)) begin
                m_cnt = 0;
                m_k++;
                if (m_k == SWEEP) begin
                    m_k      = 0;
                    m_done   = 1;
                    m_sweeps = (m_sweeps + 1) % 256;
                    if (auto_mode) begin
                        m_rep++;
                        if (m_rep == REPEAT) begin
                            m_mode = !m_mode;
                            m_rep  = 0;
                        end
                    end else begin
                        m_mode = mode_in;
                        m_rep  = 0;
                    end
                    if (old_pend) begin
                        m_busy = 0;
                        m_pend = 0;
                    end
                    done_q.push_back({m_mode, 8'(m_sweeps)});
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Issue one cycle: predict, queue the expectation, then let the edge happen.
    task automatic step();
        exp_t e;
        model_step();
        e.led  = led_of(m_k, m_mode);
        e.busy = m_busy;
        e.mode = m_mode;
        e.done = m_done;
        e.cnt  = 8'(m_sweeps);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    task automatic run_until_k(input int target, input int budget);
        for (int i = 0; i < budget && m_k != target; i++) step();
    endtask

    // Monitor: compares the outputs produced by the most recent edge.
    always @(negedge clk) begin
        exp_t e;
        logic [8:0] d;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led",        32'(led),        32'(e.led));
            check("busy",       32'(busy),       32'(e.busy));
            check("cur_mode",   32'(cur_mode),   32'(e.mode));
            check("sweep_done", 32'(sweep_done), 32'(e.done));
            check("sweep_cnt",  32'(sweep_cnt),  32'(e.cnt));
        end
        if (sweep_done === 1'b1) begin
            if (done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_event: got sweep_done=1 expected no completion at %0t", $time);
            end else begin
                d = done_q.pop_front();
                check("done_event_cnt",  32'(sweep_cnt), 32'(d[7:0]));
                check("done_event_mode", 32'(cur_mode),  32'(d[8]));
            end
        end
    end

    initial begin
        rst = 1; start = 0; stop = 0; auto_mode = 0; mode_in = 0; div = '0;
        run(2);
        rst = 0;
        run(2);

        // Left fill/drain at full speed, two sweeps.
        pulse_start();
        run(2 * SWEEP + 3);

        // Right direction; mode_in toggling mid-sweep must be ignored.
        rst = 1; step(); rst = 0;
        mode_in = 1;
        pulse_start();
        run(5);
        mode_in = 0; run(4);
        mode_in = 1; run(SWEEP);

        // div=3: one step per four cycles, then shrink div at cnt==2.
        rst = 1; step(); rst = 0;
        mode_in = 0; div = 24'd3;
        pulse_start();
        run(20);
        for (int i = 0; i < 8 && m_cnt != 2; i++) step();
        div = 24'd0;
        run(6);
        start = 1; step(); start = 0;   // start while busy is ignored
        run(SWEEP);

        // Auto mode: two sweeps each way, five sweeps total.
        rst = 1; step(); rst = 0;
        auto_mode = 1; mode_in = 0;
        pulse_start();
        run(5 * SWEEP + 2);
        auto_mode = 0;

        // Stop at led=3F during fill; sweep completes, then start+stop stays idle.
        rst = 1; step(); rst = 0;
        pulse_start();
        run_until_k(6, 4 * SWEEP);
        stop = 1; step(); stop = 0;
        run(SWEEP + 4);
        stop = 1; step();               // stop in idle is ignored
        start = 1; step(); start = 0; stop = 0;
        run(4);

        // Reset mid-drain at led=F0, then a clean restart.
        pulse_start();
        run_until_k(WIDTH + 5, 4 * SWEEP);
        rst = 1; step(); rst = 0;
        run(2);
        pulse_start();
        run(SWEEP + 2);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 599) == 0);
            start     = ($urandom_range(0, 29) == 0);
            stop      = ($urandom_range(0, 79) == 0);
            mode_in   = $urandom_range(0, 1);
            if ($urandom_range(0, 199) == 0) auto_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 49) == 0)  div = DIV_W'($urandom_range(0, 4));
            step();
        end
        rst = 0; start = 0; stop = 0;
        run(4);

        repeat (3) @(negedge clk);
        #1;
        check("exp_queue_drained",  32'(exp_q.size()),  32'd0);
        check("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
